// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes, FSM states,
// store byte-lane strobes and store-data lane replication.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // funct3[1:0] == 11 has no narrower meaning here, so it is handled as a word.
    function automatic logic [1:0] eff_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b11) ? SZ_W : f3[1:0];
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        return ((sz == SZ_H) && off[0]) || ((sz == SZ_W) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] lane_strb(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_rep(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: shifts the addressed byte/halfword down to bit 0 and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);
    logic [XLEN-1:0] sh;
    logic            sgn;

    always_comb begin
        sh     = rdata_i >> {off_i, 3'b000};
        sgn    = 1'b0;
        data_o = sh;
        case (eff_size(funct3_i))
            SZ_B: begin
                sgn    = ~funct3_i[2] & sh[7];
                data_o = {{(XLEN-8){sgn}}, sh[7:0]};
            end
            SZ_H: begin
                sgn    = ~funct3_i[2] & sh[15];
                data_o = {{(XLEN-16){sgn}}, sh[15:0]};
            end
            default: data_o = sh;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit data-bus port: one req/ready transaction per access, pipeline
// stall while it is outstanding, bus timeout, load write-back one cycle after ready.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_data_size,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [4:0]      ex_rd,
    output logic            lsu_stall,
    output logic            lsu_misalign,
    output logic            lsu_buserr,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata
);
    localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, wdata_q, wb_rdata_q, ld_data;
    logic [3:0]      wstrb_q;
    logic [1:0]      off_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q, wb_rd_q;
    logic [CW-1:0]   cnt_q;
    logic            we_q, wb_valid_q, buserr_q;

    logic [1:0] sz;
    logic       is_mem, mis, can_acc, start, timeout_hit;

    always_comb begin
        sz          = eff_size(ex_data_size);
        is_mem      = ex_valid & (ex_mem_read | ex_mem_write);
        mis         = misaligned(sz, ex_addr[1:0]);
        can_acc     = (state_q != REQ);
        start       = is_mem & ~mis & can_acc;
        timeout_hit = (TIMEOUT_CYC != 0) && (32'(cnt_q) == TIMEOUT_CYC - 1);

        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            // ready takes priority over a timeout landing in the same cycle
            REQ:     if (dmem_ready) state_d = DONE;
                     else if (timeout_hit) state_d = IDLE;
            DONE:    state_d = start ? REQ : IDLE;
            default: state_d = IDLE;
        endcase

        lsu_stall    = rst & (start | (state_q == REQ));
        lsu_misalign = rst & is_mem & mis & can_acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            we_q       <= 1'b0;
            off_q      <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_rdata_q <= '0;
            buserr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                addr_q  <= {ex_addr[XLEN-1:2], 2'b00};
                we_q    <= ex_mem_write;
                wstrb_q <= ex_mem_write ? lane_strb(sz, ex_addr[1:0]) : 4'b0000;
                wdata_q <= XLEN'(store_rep(sz, ex_wdata[31:0]));
                off_q   <= ex_addr[1:0];
                f3_q    <= ex_data_size;
                rd_q    <= ex_rd;
                cnt_q   <= '0;
            end else if (state_q == REQ && !dmem_ready) begin
                cnt_q <= cnt_q + 1'b1;
            end
            wb_valid_q <= (state_q == REQ) & dmem_ready & ~we_q;
            if ((state_q == REQ) && dmem_ready && !we_q) begin
                wb_rd_q    <= rd_q;
                wb_rdata_q <= ld_data;
            end
            buserr_q <= (state_q == REQ) & ~dmem_ready & timeout_hit;
        end
    end

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .rdata_i  (dmem_rdata),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (ld_data)
    );

    assign dmem_req   = (state_q == REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wstrb = wstrb_q;
    assign dmem_wdata = wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_rdata   = wb_rdata_q;
    assign lsu_buserr = buserr_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: stores, loads, misalignment, back-to-back,
// bus timeout and reset abandonment, with hand-computed expectations.
module tb_lsu_mem_port;
    logic        clk, rst;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_data_size;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        lsu_stall, lsu_misalign, lsu_buserr, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rdata;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_mem_port #(.XLEN(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_data_size(ex_data_size), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .lsu_stall(lsu_stall), .lsu_misalign(lsu_misalign), .lsu_buserr(lsu_buserr),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rdata(wb_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ex_idle();
        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0;
        ex_data_size = 3'b000; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    endtask

    task automatic ex_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd);
        ex_valid = 1; ex_mem_read = ~wr; ex_mem_write = wr;
        ex_data_size = f3; ex_addr = a; ex_wdata = d; ex_rd = rd;
    endtask

    task automatic test_reset();
        rst = 0; dmem_ready = 0; dmem_rdata = '0;
        ex_idle();
        @(negedge clk);
        ex_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd1);
        #1;
        if (lsu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", lsu_stall); end n_checks++;
        if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", dmem_req); end n_checks++;
        if ({wb_valid, lsu_buserr, lsu_misalign, dmem_we} !== 4'b0) begin n_fail++;
            $display("FAIL rst_flags: got %b want 0000", {wb_valid, lsu_buserr, lsu_misalign, dmem_we}); end n_checks++;
        if ({dmem_addr, dmem_wdata, wb_rdata} !== 96'h0) begin n_fail++;
            $display("FAIL rst_data: got %h %h %h want zeros", dmem_addr, dmem_wdata, wb_rdata); end n_checks++;
        ex_idle();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_store_byte();
        @(negedge clk);
        ex_op(1'b1, 3'b000, 32'h1003, 32'h0000_00AB, 5'd0);
        #1;
        if (lsu_stall !== 1'b1) begin n_fail++; $display("FAIL sb_stall_T: got %b want 1", lsu_stall); end n_checks++;
        if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL sb_req_T: got %b want 0", dmem_req); end n_checks++;
        @(negedge clk);
        ex_idle(); dmem_ready = 1;
        #1;
        if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL sb_req: got %b want 1", dmem_req); end n_checks++;
        if (lsu_stall !== 1'b1) begin n_fail++; $display("FAIL sb_stall_T1: got %b want 1", lsu_stall); end n_checks++;
        if (dmem_addr !== 32'h1000) begin n_fail++; $display("FAIL sb_addr: got %h want 00001000", dmem_addr); end n_checks++;
        if (dmem_wstrb !== 4'b1000) begin n_fail++; $display("FAIL sb_wstrb: got %b want 1000", dmem_wstrb); end n_checks++;
        if (dmem_wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata: got %h want abababab", dmem_wdata); end n_checks++;
        if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL sb_we: got %b want 1", dmem_we); end n_checks++;
        @(negedge clk);
        dmem_ready = 0;
        #1;
        if ({dmem_req, lsu_stall, wb_valid} !== 3'b000) begin n_fail++;
            $display("FAIL sb_done: req/stall/wbv got %b want 000", {dmem_req, lsu_stall, wb_valid}); end n_checks++;
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] exp);
        @(negedge clk);
        ex_op(1'b0, f3, 32'h2002, 32'h0, rd);
        #1;
        if (lsu_stall !== 1'b1) begin n_fail++; $display("FAIL lb_stall_T: got %b want 1", lsu_stall); end n_checks++;
        @(negedge clk);
        ex_idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            if ({dmem_req, lsu_stall, dmem_we} !== 3'b110) begin n_fail++;
                $display("FAIL lb_wait%0d: req/stall/we got %b want 110", i, {dmem_req, lsu_stall, dmem_we}); end n_checks++;
            @(negedge clk);
        end
        dmem_ready = 1; dmem_rdata = 32'h12F4_5678;
        #1;
        if ({dmem_req, lsu_stall, wb_valid} !== 3'b110) begin n_fail++;
            $display("FAIL lb_T4: req/stall/wbv got %b want 110", {dmem_req, lsu_stall, wb_valid}); end n_checks++;
        if (dmem_addr !== 32'h2000) begin n_fail++; $display("FAIL lb_addr: got %h want 00002000", dmem_addr); end n_checks++;
        @(negedge clk);
        dmem_ready = 0; dmem_rdata = 32'hDEAD_DEAD;
        #1;
        if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL lb_wbv: got %b want 1", wb_valid); end n_checks++;
        if (wb_rdata !== exp) begin n_fail++; $display("FAIL lb_rdata: got %h want %h", wb_rdata, exp); end n_checks++;
        if (wb_rd !== rd) begin n_fail++; $display("FAIL lb_rd: got %0d want %0d", wb_rd, rd); end n_checks++;
        if ({dmem_req, lsu_stall} !== 2'b00) begin n_fail++; $display("FAIL lb_T5: req/stall got %b want 00", {dmem_req, lsu_stall}); end n_checks++;
        @(negedge clk);
        #1;
        if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL lb_wbv_pulse: got %b want 0", wb_valid); end n_checks++;
    endtask

    task automatic test_misalign();
        @(negedge clk);
        ex_op(1'b0, 3'b001, 32'h3001, 32'h0, 5'd2);
        #1;
        if (lsu_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b want 1", lsu_misalign); end n_checks++;
        if (lsu_stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall: got %b want 0", lsu_stall); end n_checks++;
        @(negedge clk);
        ex_idle();
        #1;
        if ({dmem_req, lsu_misalign, lsu_stall} !== 3'b000) begin n_fail++;
            $display("FAIL mis_after: req/mis/stall got %b want 000", {dmem_req, lsu_misalign, lsu_stall}); end n_checks++;
        // misaligned word store
        ex_op(1'b1, 3'b010, 32'h3002, 32'h1, 5'd0);
        #1;
        if ({lsu_misalign, lsu_stall} !== 2'b10) begin n_fail++;
            $display("FAIL mis_sw: mis/stall got %b want 10", {lsu_misalign, lsu_stall}); end n_checks++;
        @(negedge clk);
        ex_idle();
        #1;
        if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL mis_sw_req: got %b want 0", dmem_req); end n_checks++;
    endtask

    task automatic test_half();
        @(negedge clk);
        ex_op(1'b1, 3'b001, 32'h7002, 32'h1234_BEEF, 5'd0);
        @(negedge clk);
        ex_idle(); dmem_ready = 1;
        #1;
        if (dmem_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sh_wstrb: got %b want 1100", dmem_wstrb); end n_checks++;
        if (dmem_wdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_wdata: got %h want beefbeef", dmem_wdata); end n_checks++;
        @(negedge clk);
        dmem_ready = 0;
        ex_op(1'b0, 3'b001, 32'h7002, 32'h0, 5'd9);
        @(negedge clk);
        ex_idle(); dmem_ready = 1; dmem_rdata = 32'h8001_5555;
        @(negedge clk);
        dmem_ready = 0;
        #1;
        if (wb_rdata !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_rdata: got %h want ffff8001", wb_rdata); end n_checks++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        ex_op(1'b1, 3'b010, 32'h4000, 32'hDEAD_BEEF, 5'd0);
        @(negedge clk);
        ex_idle(); dmem_ready = 1;
        #1;
        if ({dmem_wstrb, dmem_wdata} !== {4'b1111, 32'hDEAD_BEEF}) begin n_fail++;
            $display("FAIL b2b_sw: got %b %h want 1111 deadbeef", dmem_wstrb, dmem_wdata); end n_checks++;
        @(negedge clk);
        dmem_ready = 0;
        ex_op(1'b0, 3'b010, 32'h4004, 32'h0, 5'd7);
        #1;
        if ({dmem_req, lsu_stall} !== 2'b01) begin n_fail++;
            $display("FAIL b2b_done: req/stall got %b want 01", {dmem_req, lsu_stall}); end n_checks++;
        @(negedge clk);
        ex_idle(); dmem_ready = 1; dmem_rdata = 32'hCAFE_F00D;
        #1;
        if ({dmem_req, dmem_we, dmem_addr} !== {2'b10, 32'h4004}) begin n_fail++;
            $display("FAIL b2b_req2: req/we %b%b addr %h want 10 00004004", dmem_req, dmem_we, dmem_addr); end n_checks++;
        @(negedge clk);
        dmem_ready = 0;
        #1;
        if ({wb_valid, wb_rd, wb_rdata} !== {1'b1, 5'd7, 32'hCAFE_F00D}) begin n_fail++;
            $display("FAIL b2b_wb: got %b %0d %h want 1 7 cafef00d", wb_valid, wb_rd, wb_rdata); end n_checks++;
    endtask

    task automatic test_timeout();
        @(negedge clk);
        ex_op(1'b0, 3'b010, 32'h5000, 32'h0, 5'd4);
        @(negedge clk);
        ex_idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            if ({dmem_req, lsu_stall, lsu_buserr} !== 3'b110) begin n_fail++;
                $display("FAIL to_req%0d: req/stall/err got %b want 110", i, {dmem_req, lsu_stall, lsu_buserr}); end n_checks++;
            @(negedge clk);
        end
        #1;
        if ({dmem_req, lsu_stall, lsu_buserr, wb_valid} !== 4'b0010) begin n_fail++;
            $display("FAIL to_end: req/stall/err/wbv got %b want 0010", {dmem_req, lsu_stall, lsu_buserr, wb_valid}); end n_checks++;
        @(negedge clk);
        #1;
        if ({dmem_req, lsu_buserr} !== 2'b00) begin n_fail++;
            $display("FAIL to_pulse: req/err got %b want 00", {dmem_req, lsu_buserr}); end n_checks++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ex_op(1'b0, 3'b010, 32'h6000, 32'h0, 5'd8);
        @(negedge clk);
        ex_idle();
        #1;
        if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rm_req_pre: got %b want 1", dmem_req); end n_checks++;
        rst = 0;
        #1;
        if ({dmem_req, lsu_stall} !== 2'b00) begin n_fail++;
            $display("FAIL rm_async: req/stall got %b want 00", {dmem_req, lsu_stall}); end n_checks++;
        dmem_ready = 1; dmem_rdata = 32'h5555_5555;
        @(negedge clk);
        dmem_ready = 0;
        rst = 1;
        #1;
        if ({wb_valid, lsu_buserr, dmem_req} !== 3'b000) begin n_fail++;
            $display("FAIL rm_after: wbv/err/req got %b want 000", {wb_valid, lsu_buserr, dmem_req}); end n_checks++;
        @(negedge clk);
        ex_op(1'b0, 3'b010, 32'h6008, 32'h0, 5'd3);
        @(negedge clk);
        ex_idle(); dmem_ready = 1; dmem_rdata = 32'h1122_3344;
        @(negedge clk);
        dmem_ready = 0;
        #1;
        if ({wb_valid, wb_rd, wb_rdata} !== {1'b1, 5'd3, 32'h1122_3344}) begin n_fail++;
            $display("FAIL rm_clean_lw: got %b %0d %h want 1 3 11223344", wb_valid, wb_rd, wb_rdata); end n_checks++;
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_byte(3'b000, 5'd5, 32'hFFFF_FFF4);
        test_load_byte(3'b100, 5'd6, 32'h0000_00F4);
        test_misalign();
        test_half();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
